// File: rtl/axi_lite_master_bridge.sv
// Bridges the CPU single-outstanding load/store port onto an AXI4-Lite master interface.
// Optional AXI_POSTED_WRITE_EN: stores complete to the CPU once AW and W are done, B is tracked.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,

  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  input  logic [3:0]            cpu_req_wstrb,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  cpu_resp_err,
  output logic                  posted_wr_err,

  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  b_pending_q;
  logic                  posted_err_q;

  logic req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_both_done;

  // Only bit 1 of BRESP/RRESP distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_resp_lsb;
  assign unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

  assign cpu_req_ready  = (state_q == StIdle) && !b_pending_q;
  assign m_awvalid      = (state_q == StWrAddrData) && !aw_done_q;
  assign m_wvalid       = (state_q == StWrAddrData) && !w_done_q;
  assign m_bready       = (state_q == StWrResp) || b_pending_q;
  assign m_arvalid      = (state_q == StRdAddr);
  assign m_rready       = (state_q == StRdData);
  assign cpu_resp_valid = (state_q == StDone);

  assign m_awaddr       = addr_q;
  assign m_araddr       = addr_q;
  assign m_wdata        = wdata_q;
  assign m_wstrb        = wstrb_q;
  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_err   = err_q;
  assign posted_wr_err  = posted_err_q;

  assign req_hs = cpu_req_valid && cpu_req_ready;
  assign aw_hs  = m_awvalid && m_awready;
  assign w_hs   = m_wvalid && m_wready;
  assign b_hs   = m_bvalid && m_bready;
  assign ar_hs  = m_arvalid && m_arready;
  assign r_hs   = m_rvalid && m_rready;

  assign wr_both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        if (req_hs) begin
          addr_d    = cpu_req_addr;
          wdata_d   = cpu_req_wdata;
          wstrb_d   = cpu_req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cpu_req_write ? StWrAddrData : StRdAddr;
        end
      end
      StWrAddrData: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (wr_both_done) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXI_POSTED_WRITE_EN
          err_d     = 1'b0;
          state_d   = StDone;
`else
          state_d   = StWrResp;
`endif
        end
      end
      StWrResp: begin
        if (b_hs) begin
          err_d   = m_bresp[1];
          state_d = StDone;
        end
      end
      StRdAddr: begin
        if (ar_hs) state_d = StRdData;
      end
      StRdData: begin
        if (r_hs) begin
          rdata_d = m_rdata;
          err_d   = m_rresp[1];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef AXI_POSTED_WRITE_EN
  logic b_pending_d;
  logic posted_err_d;

  // The B of a posted store is absorbed here; new requests are held off until it lands.
  always_comb begin
    b_pending_d  = b_pending_q;
    posted_err_d = posted_err_q;
    if ((state_q == StWrAddrData) && wr_both_done) begin
      b_pending_d = 1'b1;
    end else if (b_pending_q && m_bvalid) begin
      b_pending_d = 1'b0;
      if (m_bresp[1]) posted_err_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      b_pending_q  <= 1'b0;
      posted_err_q <= 1'b0;
    end else begin
      b_pending_q  <= b_pending_d;
      posted_err_q <= posted_err_d;
    end
  end
`else
  assign b_pending_q  = 1'b0;
  assign posted_err_q = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a configurable-latency AXI4-Lite slave.
// Build with AXI_POSTED_WRITE_EN defined to exercise the posted-write variant.
module tb_axi_lite_master_bridge;

`ifdef AXI_POSTED_WRITE_EN
  localparam bit Posted = 1'b1;
`else
  localparam bit Posted = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_write = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic [3:0]  cpu_req_wstrb = '0;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;
  logic        posted_wr_err;

  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  axi_lite_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_write (cpu_req_write),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wstrb (cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .cpu_resp_err  (cpu_resp_err),
    .posted_wr_err (posted_wr_err),
    .m_awaddr      (m_awaddr),
    .m_awvalid     (m_awvalid),
    .m_awready     (m_awready),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_wvalid      (m_wvalid),
    .m_wready      (m_wready),
    .m_bresp       (m_bresp),
    .m_bvalid      (m_bvalid),
    .m_bready      (m_bready),
    .m_araddr      (m_araddr),
    .m_arvalid     (m_arvalid),
    .m_arready     (m_arready),
    .m_rdata       (m_rdata),
    .m_rresp       (m_rresp),
    .m_rvalid      (m_rvalid),
    .m_rready      (m_rready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave configuration and observation state.
  int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [31:0] cfg_rdata = '0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int          awv_cycles = 0, wv_cycles = 0;
  int          overlap = 0;
  int          cyc = 0;
  int          accept_cyc[$];
  int          resp_cyc[$];
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;

  // Slave runs on the falling edge; a handshake counted here happens at the next rising edge.
  always @(negedge cpu_clk) begin
    cyc++;
    if (cpu_rst) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
      m_bresp = '0; m_rresp = '0; m_rdata = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    end else begin
      if (cpu_resp_valid) resp_cyc.push_back(cyc);
      if (cpu_req_valid && cpu_req_ready) accept_cyc.push_back(cyc);
      if ((m_awvalid || m_wvalid || m_bready) && (m_arvalid || m_rready)) overlap++;

      if (aw_hs > b_hs && w_hs > b_hs) begin
        m_bvalid = (b_cnt >= cfg_b_wait);
        m_bresp  = cfg_bresp;
        b_cnt++;
        if (m_bvalid && m_bready) begin b_hs++; b_cnt = 0; end
      end else begin
        m_bvalid = 1'b0; m_bresp = '0; b_cnt = 0;
      end

      if (ar_hs > r_hs) begin
        m_rvalid = (r_cnt >= cfg_r_wait);
        m_rresp  = cfg_rresp;
        m_rdata  = cfg_rdata;
        r_cnt++;
        if (m_rvalid && m_rready) begin r_hs++; r_cnt = 0; end
      end else begin
        m_rvalid = 1'b0; m_rresp = '0; m_rdata = '0; r_cnt = 0;
      end

      if (m_awvalid) begin
        m_awready = (aw_cnt >= cfg_aw_wait);
        aw_cnt++; awv_cycles++;
        if (m_awready) begin aw_hs++; aw_cnt = 0; cap_awaddr = m_awaddr; end
      end else begin
        m_awready = 1'b0; aw_cnt = 0;
      end

      if (m_wvalid) begin
        m_wready = (w_cnt >= cfg_w_wait);
        w_cnt++; wv_cycles++;
        if (m_wready) begin w_hs++; w_cnt = 0; cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
      end else begin
        m_wready = 1'b0; w_cnt = 0;
      end

      if (m_arvalid) begin
        m_arready = (ar_cnt >= cfg_ar_wait);
        ar_cnt++;
        if (m_arready) begin ar_hs++; ar_cnt = 0; cap_araddr = m_araddr; end
      end else begin
        m_arready = 1'b0; ar_cnt = 0;
      end
    end
  end

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_req_valid = 1'b1; cpu_req_write = wr;
    cpu_req_addr = addr; cpu_req_wdata = wdata; cpu_req_wstrb = strb;
    for (int i = 0; i < 200; i++) begin
      @(negedge cpu_clk); #1;
      if (cpu_req_ready) begin ok = 1'b1; break; end
    end
    chk_b("req_accept_timeout", ok, 1'b1);
    @(posedge cpu_clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge cpu_clk); #1;
      if (cpu_resp_valid) begin found = 1'b1; break; end
    end
    chk_b("resp_timeout", found, 1'b1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_w, w_w, b_w, ar_w, r_w;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_awv, exp_wv;
  } vec_t;

  vec_t vt [8];

  initial begin
    int a0, r0, b0;
    logic ok;

    vt[0] = '{1'b1, 32'h4000_0000, 32'h0003_0025, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,
              32'h0000_0000, 1'b0, 1, 1};
    vt[1] = '{1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'h3, 2, 0, 0, 0, 0, 2'b00, 32'h0,
              32'h0000_0000, 1'b0, 3, 1};
    vt[2] = '{1'b0, 32'h4000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h0000_0000,
              32'h0000_0000, 1'b1, 0, 0};
    vt[3] = '{1'b0, 32'h4000_000C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0001_0007,
              32'h0001_0007, 1'b0, 0, 0};
    vt[4] = '{1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'hC, 0, 2, 0, 0, 0, 2'b11, 32'h0,
              32'h0001_0007, 1'b1, 1, 3};
    vt[5] = '{1'b0, 32'h4000_0014, 32'h0, 4'h0, 0, 0, 0, 3, 2, 2'b00, 32'hA5A5_5A5A,
              32'hA5A5_5A5A, 1'b0, 0, 0};
    vt[6] = '{1'b1, 32'h4000_0018, 32'h1234_5678, 4'h1, 1, 1, 3, 0, 0, 2'b10, 32'h0,
              32'hA5A5_5A5A, 1'b1, 2, 2};
    vt[7] = '{1'b0, 32'h4000_001C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h8765_4321,
              32'h8765_4321, 1'b1, 0, 0};

    // Reset state.
    #1 cpu_rst = 1'b1;
    repeat (2) @(negedge cpu_clk);
    #1;
    chk_b("rst_req_ready", cpu_req_ready, 1'b1);
    chk_b("rst_awvalid", m_awvalid, 1'b0);
    chk_b("rst_wvalid", m_wvalid, 1'b0);
    chk_b("rst_arvalid", m_arvalid, 1'b0);
    chk_b("rst_bready", m_bready, 1'b0);
    chk_b("rst_rready", m_rready, 1'b0);
    chk_b("rst_resp_valid", cpu_resp_valid, 1'b0);
    chk_w("rst_resp_rdata", cpu_resp_rdata, 32'h0);
    chk_b("rst_resp_err", cpu_resp_err, 1'b0);
    chk_b("rst_posted_err", posted_wr_err, 1'b0);
    cpu_rst = 1'b0;
    @(negedge cpu_clk); #1;
    chk_b("post_rst_req_ready", cpu_req_ready, 1'b1);

    // Table-driven single transactions.
    for (int i = 0; i < 8; i++) begin
      cfg_aw_wait = vt[i].aw_w; cfg_w_wait = vt[i].w_w; cfg_b_wait = vt[i].b_w;
      cfg_ar_wait = vt[i].ar_w; cfg_r_wait = vt[i].r_w;
      cfg_bresp = vt[i].resp; cfg_rresp = vt[i].resp; cfg_rdata = vt[i].rdata;
      awv_cycles = 0; wv_cycles = 0;
      do_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb);
      wait_resp();
      chk_w($sformatf("v%0d_rdata", i), cpu_resp_rdata, vt[i].exp_rdata);
      chk_b($sformatf("v%0d_err", i), cpu_resp_err,
            (vt[i].wr && Posted) ? 1'b0 : vt[i].exp_err);
      if (vt[i].wr) begin
        chk_w($sformatf("v%0d_awaddr", i), cap_awaddr, vt[i].addr);
        chk_w($sformatf("v%0d_wdata", i), cap_wdata, vt[i].wdata);
        chk_w($sformatf("v%0d_wstrb", i), {28'h0, cap_wstrb}, {28'h0, vt[i].wstrb});
        chk_i($sformatf("v%0d_awvalid_cycles", i), awv_cycles, vt[i].exp_awv);
        chk_i($sformatf("v%0d_wvalid_cycles", i), wv_cycles, vt[i].exp_wv);
      end else begin
        chk_w($sformatf("v%0d_araddr", i), cap_araddr, vt[i].addr);
      end
      @(negedge cpu_clk); #1;
      chk_b($sformatf("v%0d_resp_one_cycle", i), cpu_resp_valid, 1'b0);
    end

    // Let any outstanding posted B drain, then check the sticky error flag.
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cpu_req_ready) begin ok = 1'b1; break; end
      @(negedge cpu_clk); #1;
    end
    chk_b("drain_timeout", ok, 1'b1);
    chk_b("posted_err_after_table", posted_wr_err, Posted);

    // Back-to-back store then load with cpu_req_valid held high.
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_ar_wait = 0; cfg_r_wait = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0BAD_F00D;
    a0 = accept_cyc.size(); r0 = resp_cyc.size();
    @(posedge cpu_clk); #1;
    cpu_req_valid = 1'b1; cpu_req_write = 1'b1;
    cpu_req_addr = 32'h4000_0020; cpu_req_wdata = 32'h1111_2222; cpu_req_wstrb = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge cpu_clk); #1;
      if (accept_cyc.size() == a0 + 1) begin ok = 1'b1; break; end
    end
    chk_b("b2b_first_accept", ok, 1'b1);
    @(posedge cpu_clk); #1;
    cpu_req_write = 1'b0; cpu_req_addr = 32'h4000_0024; cpu_req_wdata = '0; cpu_req_wstrb = '0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge cpu_clk); #1;
      if (accept_cyc.size() == a0 + 2) begin ok = 1'b1; break; end
    end
    chk_b("b2b_second_accept", ok, 1'b1);
    @(posedge cpu_clk); #1;
    cpu_req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge cpu_clk); #1;
      if (resp_cyc.size() == r0 + 2) begin ok = 1'b1; break; end
    end
    chk_b("b2b_second_resp", ok, 1'b1);
    chk_w("b2b_load_rdata", cpu_resp_rdata, 32'h0BAD_F00D);
    chk_b("b2b_load_err", cpu_resp_err, 1'b0);
    chk_w("b2b_store_awaddr", cap_awaddr, 32'h4000_0020);
    chk_i("b2b_accept_after_resp", accept_cyc[a0 + 1], resp_cyc[r0] + 1);
    chk_i("b2b_channel_overlap", overlap, 0);

    // Asynchronous reset while a read address is outstanding.
    cfg_ar_wait = 1000;
    do_req(1'b0, 32'h4000_0028, 32'h0, 4'h0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_arvalid) begin ok = 1'b1; break; end
      @(negedge cpu_clk); #1;
    end
    chk_b("rst_mid_arvalid_seen", ok, 1'b1);
    r0 = resp_cyc.size();
    #2 cpu_rst = 1'b1;
    #1;
    chk_b("rst_mid_arvalid", m_arvalid, 1'b0);
    chk_b("rst_mid_rready", m_rready, 1'b0);
    chk_b("rst_mid_awvalid", m_awvalid, 1'b0);
    chk_b("rst_mid_wvalid", m_wvalid, 1'b0);
    chk_b("rst_mid_bready", m_bready, 1'b0);
    chk_b("rst_mid_resp_valid", cpu_resp_valid, 1'b0);
    chk_w("rst_mid_rdata", cpu_resp_rdata, 32'h0);
    repeat (2) @(negedge cpu_clk);
    #1 cpu_rst = 1'b0;
    cfg_ar_wait = 0;
    repeat (6) @(negedge cpu_clk);
    #1;
    chk_b("rst_mid_ready_after", cpu_req_ready, 1'b1);
    chk_b("rst_mid_no_arvalid", m_arvalid, 1'b0);
    chk_i("rst_mid_no_resp", resp_cyc.size(), r0);

    // Store with an error B arriving late.
    cfg_b_wait = 5; cfg_bresp = 2'b10;
`ifdef AXI_POSTED_WRITE_EN
    chk_b("posted_err_clear", posted_wr_err, 1'b0);
    b0 = b_hs;
    do_req(1'b1, 32'h4000_0030, 32'h0000_00AA, 4'hF);
    wait_resp();
    chk_b("posted_resp_err", cpu_resp_err, 1'b0);
    chk_i("posted_resp_before_b", b_hs, b0);
    @(negedge cpu_clk); #1;
    chk_b("posted_ready_blocked", cpu_req_ready, 1'b0);
    chk_b("posted_bready", m_bready, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (b_hs > b0) begin ok = 1'b1; break; end
      @(negedge cpu_clk); #1;
    end
    chk_b("posted_b_timeout", ok, 1'b1);
    @(negedge cpu_clk); #1;
    chk_b("posted_ready_after_b", cpu_req_ready, 1'b1);
    chk_b("posted_err_set", posted_wr_err, 1'b1);
    cfg_b_wait = 0; cfg_bresp = 2'b00; cfg_rdata = 32'h0000_0042; cfg_rresp = 2'b00;
    do_req(1'b0, 32'h4000_0034, 32'h0, 4'h0);
    wait_resp();
    chk_w("posted_load_rdata", cpu_resp_rdata, 32'h0000_0042);
    chk_b("posted_err_sticky", posted_wr_err, 1'b1);
    cpu_rst = 1'b1;
    #1;
    chk_b("posted_err_rst", posted_wr_err, 1'b0);
    @(negedge cpu_clk);
    #1 cpu_rst = 1'b0;
`else
    b0 = b_hs;
    do_req(1'b1, 32'h4000_0030, 32'h0000_00AA, 4'hF);
    wait_resp();
    chk_b("late_b_resp_err", cpu_resp_err, 1'b1);
    chk_i("late_b_done_before_resp", b_hs, b0 + 1);
    chk_b("late_b_posted_err", posted_wr_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
